// File: rtl/sub_bytes_req.sv
// AES SubBytes request engine: splits a state block into four words, sends them
// MSB word first to a shared S-box LUT and reassembles the substituted block.
module sub_bytes_req #(
  parameter int BLOCK_W = 128,
  parameter int WORD_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sbox_available,
  input  logic [BLOCK_W-1:0] blk_in,
  input  logic               blk_in_vld,
  output logic               blk_in_rdy,
  output logic [WORD_W-1:0]  sub_bytes_val,
  output logic               sub_bytes_val_vld,
  input  logic [WORD_W-1:0]  sub_bytes_sbox_data,
  input  logic               sub_bytes_sbox_data_vld,
  output logic [BLOCK_W-1:0] blk_out,
  output logic               blk_out_vld,
  input  logic               blk_out_rdy,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, LOOKUP, DONE} state_t;

  state_t             state_q, state_d;
  logic               table_loaded_q, table_loaded_d;
  logic [1:0]         wcnt_q, wcnt_d;
  logic [BLOCK_W-1:0] blk_q, blk_d;
  logic [BLOCK_W-1:0] result_q, result_d;

  // Word 0 is the most significant word of the block.
  function automatic logic [WORD_W-1:0] word_sel(input logic [BLOCK_W-1:0] b,
                                                 input logic [1:0] idx);
    return b[BLOCK_W-1-WORD_W*int'(idx) -: WORD_W];
  endfunction

  always_comb begin
    state_d        = state_q;
    table_loaded_d = table_loaded_q | sbox_available;
    wcnt_d         = wcnt_q;
    blk_d          = blk_q;
    result_d       = result_q;
    case (state_q)
      IDLE: begin
        if (blk_in_vld && table_loaded_q) begin
          blk_d   = blk_in;
          wcnt_d  = 2'd0;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (sub_bytes_sbox_data_vld) begin
          result_d[BLOCK_W-1-WORD_W*int'(wcnt_q) -: WORD_W] = sub_bytes_sbox_data;
          wcnt_d = wcnt_q + 2'd1;
          if (wcnt_q == 2'd3) state_d = DONE;
        end
      end
      DONE: begin
        if (blk_out_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      table_loaded_q <= 1'b0;
      wcnt_q         <= 2'd0;
      result_q       <= '0;
    end else begin
      state_q        <= state_d;
      table_loaded_q <= table_loaded_d;
      wcnt_q         <= wcnt_d;
      result_q       <= result_d;
    end
  end

  // Captured input block; only consumed while in LOOKUP, so no reset needed
  always_ff @(posedge clk) begin
    blk_q <= blk_d;
  end

  // Outputs are forced low while reset is asserted.
  assign blk_in_rdy        = !reset && (state_q == IDLE) && table_loaded_q;
  assign sub_bytes_val_vld = !reset && (state_q == LOOKUP);
  assign sub_bytes_val     = sub_bytes_val_vld ? word_sel(blk_q, wcnt_q) : '0;
  assign blk_out_vld       = !reset && (state_q == DONE);
  assign blk_out           = blk_out_vld ? result_q : '0;
  assign busy              = !reset && (state_q != IDLE);

endmodule

// File: doc/sub_bytes_req.md
SUB_BYTES_REQ -- requirements
Module: sub_bytes_req

Interface
REQ-001 The block SHALL have parameter BLOCK_W, default 128, meaning the AES state width in bits.
REQ-002 The block SHALL have parameter WORD_W, default 32 (`WORD_DATA_WIDTH), meaning the sbox lookup word width; BLOCK_W SHALL equal 4*WORD_W.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all logic rising-edge.
REQ-004 The block SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-005 The block SHALL have port sbox_available, input, 1, meaning a pulse from the sbox LUT indicating the table has been written.
REQ-006 The block SHALL have port blk_in, input, BLOCK_W, meaning the state block to substitute.
REQ-007 The block SHALL have port blk_in_vld, input, 1, meaning blk_in is valid.
REQ-008 The block SHALL have port blk_in_rdy, output, 1, meaning the block accepts blk_in this cycle.
REQ-009 The block SHALL have port sub_bytes_val, output, WORD_W, meaning the word sent to the sbox LUT.
REQ-010 The block SHALL have port sub_bytes_val_vld, output, 1, meaning sub_bytes_val is valid.
REQ-011 The block SHALL have port sub_bytes_sbox_data, input, WORD_W, meaning the substituted word returned by the LUT.
REQ-012 The block SHALL have port sub_bytes_sbox_data_vld, input, 1, meaning sub_bytes_sbox_data is valid.
REQ-013 The block SHALL have port blk_out, output, BLOCK_W, meaning the substituted block.
REQ-014 The block SHALL have port blk_out_vld, output, 1, meaning blk_out is valid.
REQ-015 The block SHALL have port blk_out_rdy, input, 1, meaning the consumer accepts blk_out.
REQ-016 The block SHALL have port busy, output, 1, meaning the FSM is not in IDLE.

Function
REQ-017 The block SHALL set an internal table_loaded flag on any cycle sbox_available=1; only reset SHALL clear it.
REQ-018 The FSM SHALL have the states IDLE, LOOKUP, and DONE.
REQ-019 blk_in_rdy SHALL equal 1 exactly when state=IDLE and table_loaded=1.
REQ-020 An input handshake is blk_in_vld&blk_in_rdy; on it, the block SHALL register blk_in, clear the word counter wcnt[1:0] to 0, and go to LOOKUP.
REQ-021 In LOOKUP, the block SHALL drive sub_bytes_val_vld=1 and sub_bytes_val=blk_reg word wcnt, where word 0=[BLOCK_W-1:3*WORD_W], MSB word first, through word 3=[WORD_W-1:0].
REQ-022 In LOOKUP, if sub_bytes_sbox_data_vld=1 in the same cycle, the block SHALL write sub_bytes_sbox_data into result word position wcnt and increment wcnt.
REQ-023 In LOOKUP, if sub_bytes_sbox_data_vld=0, the block SHALL hold wcnt, result, and sub_bytes_val unchanged (stall).
REQ-024 Capture of word 3 SHALL move the state to DONE; wcnt SHALL wrap to 0.
REQ-025 Outside LOOKUP, sub_bytes_val_vld SHALL be 0 and sub_bytes_val SHALL be all-zero.
REQ-026 In DONE, blk_out_vld SHALL be 1, and blk_out SHALL hold the result stable until blk_out_rdy=1; the state SHALL then return to IDLE.
REQ-027 With no stalls, latency SHALL be: handshake at cycle N, lookups at N+1..N+4, blk_out_vld at N+5; throughput SHALL be at most one block per 6 cycles.
REQ-028 blk_in_vld SHALL be ignored outside IDLE, and while table_loaded=0.
REQ-029 An sbox_available pulse during LOOKUP or DONE SHALL not disturb the operation in progress.
REQ-030 blk_out SHALL be all-zero whenever blk_out_vld=0.

Reset
REQ-031 reset=1 SHALL have priority over all other inputs on the same edge.
REQ-032 On reset=1, the FSM SHALL go to IDLE, and wcnt=0, table_loaded=0, and the result register=0.
REQ-033 Outputs SHALL be 0 during and after reset: blk_in_rdy, sub_bytes_val_vld, sub_bytes_val, blk_out_vld, blk_out, busy.
REQ-034 reset mid-LOOKUP or mid-DONE SHALL abort the block in progress with no output produced.

Verification
REQ-035 Load check: with no sbox_available pulse, blk_in_vld=1 -> blk_in_rdy stays 0; after the pulse, blk_in_rdy=1 next cycle.
REQ-036 AES S-box model check: blk_in=128'h00010253_00000000_00000000_00000000 -> blk_out=128'h637c77ed_63636363_63636363_63636363, and blk_out_vld rises 5 cycles after the handshake.
REQ-037 Stall check: sub_bytes_sbox_data_vld held 0 for 3 cycles during word 1 -> sub_bytes_val holds word 1, and blk_out_vld is delayed by exactly 3 cycles with a correct result.
REQ-038 Backpressure check: blk_out_rdy=0 for 10 cycles -> blk_out stable, blk_in_rdy=0, and the next block is accepted only after the blk_out handshake.
REQ-039 Reset mid-op check: reset asserted with wcnt=2 -> next cycle all outputs 0 and table_loaded=0, and the block is not accepted until a new sbox_available pulse.
